// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART transmit and receive paths. Keeping the
//   parity encoding here means TX parity generation and RX parity checking
//   cannot drift apart.
//
//   Contents:
//     UART_DATA_WIDTH : default number of data bits per frame
//     PAR_ODD/PAR_EVEN: encoding of the par_typ control bit
//     uart_state_e    : frame FSM states (IDLE, START, DATA, PARITY, STOP)
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    localparam logic PAR_ODD  = 1'b1;
    localparam logic PAR_EVEN = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// ----------------------------------------------------------------------------
// uart_tx_serializer
//   Data-bit shift register and bit counter for the UART transmitter.
//   Loads the whole byte on accept, shifts right (LSB first) on each
//   bit-advance strobe while the FSM is in DATA.
//
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     load_i       : capture data_i and clear the bit counter
//     shift_i      : advance to the next data bit
//     data_i       : byte to serialize
//     ser_bit_o    : data bit that will be on the line after this edge
//     ser_done_o   : the bit currently being sent is the last data bit
// ----------------------------------------------------------------------------
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  shift_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ser_bit_o,
    output logic                  ser_done_o
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;

    assign ser_done_o = (bit_cnt_q == CNT_W'(DATA_WIDTH - 1));

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        if (load_i) begin
            shift_d   = data_i;
            bit_cnt_d = '0;
        end else if (shift_i) begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = ser_done_o ? '0 : bit_cnt_q + 1'b1;
        end
    end

    // The line register in the top samples this, so it must be the
    // post-shift LSB rather than the current one.
    assign ser_bit_o = shift_d[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx
//   UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional
//   parity bit, stop bit(s). Each bit lasts max(prescale,1) clk cycles.
//   Build option: define UART_TX_STOP2_EN for two stop bits (default one).
//
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     tx_data     : byte to send, taken when tx_valid && tx_ready
//     tx_valid    : tx_data valid; ignored while a frame is in progress
//     par_en      : 1 = append parity bit
//     par_typ     : PAR_ODD / PAR_EVEN
//     prescale    : clk cycles per bit (0 behaves as 1)
//     tx_ready    : idle, can accept a byte (registered)
//     busy        : frame in progress, always !tx_ready (registered)
//     tx_out      : serial line, idle high (registered)
// ----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tx_ready,
    output logic                  busy,
    output logic                  tx_out
);

`ifdef UART_TX_STOP2_EN
    localparam logic STOP2 = 1'b1;
`else
    localparam logic STOP2 = 1'b0;
`endif

    uart_state_e           state_q, state_d;
    logic [PRESCALE_W-1:0] pm1_q;      // bit time minus one
    logic [PRESCALE_W-1:0] cnt_q;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic                  stop_cnt_q; // second stop bit in progress
    logic                  tx_out_q, tx_out_d;
    logic                  tx_ready_q;
    logic                  busy_q;

    logic                  load, shift_en, adv, stop_last;
    logic                  par_calc;
    logic [PRESCALE_W-1:0] prescale_m1;
    logic                  ser_bit, ser_done;

    assign prescale_m1 = (prescale == '0) ? '0 : prescale - 1'b1;
    assign adv         = (state_q != IDLE) && (cnt_q == pm1_q);
    assign stop_last   = STOP2 ? stop_cnt_q : 1'b1;

    always_comb begin
        par_calc = ^tx_data;
        case (par_typ)
            PAR_ODD:  par_calc = ~^tx_data;
            PAR_EVEN: par_calc = ^tx_data;
            default:  par_calc = ^tx_data;
        endcase
    end

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .shift_i    (shift_en),
        .data_i     (tx_data),
        .ser_bit_o  (ser_bit),
        .ser_done_o (ser_done)
    );

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d = START;
                    load    = 1'b1;
                end
            end
            START: begin
                if (adv) state_d = DATA;
            end
            DATA: begin
                if (adv) begin
                    shift_en = 1'b1;
                    if (ser_done) state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (adv) state_d = STOP;
            end
            STOP: begin
                if (adv && stop_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Line value is decoded from the next state so tx_out can be a
        // plain register and changes on the same edge as the state.
        tx_out_d = 1'b1;
        case (state_d)
            START:   tx_out_d = 1'b0;
            DATA:    tx_out_d = ser_bit;
            PARITY:  tx_out_d = par_bit_q;
            default: tx_out_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_out_q   <= 1'b1;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_out_q   <= tx_out_d;
            tx_ready_q <= (state_d == IDLE);
            busy_q     <= (state_d != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pm1_q      <= '0;
            cnt_q      <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop_cnt_q <= 1'b0;
        end else begin
            if (load) begin
                pm1_q     <= prescale_m1;
                par_en_q  <= par_en;
                par_bit_q <= par_calc;
            end

            if (load || adv)           cnt_q <= '0;
            else if (state_q != IDLE)  cnt_q <= cnt_q + 1'b1;

            if (load)                          stop_cnt_q <= 1'b0;
            else if (adv && state_q == STOP)   stop_cnt_q <= 1'b1;
        end
    end

    assign tx_out   = tx_out_q;
    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    localparam int DW = 8;
    localparam int PW = 6;
`ifdef UART_TX_STOP2_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          par_en = 1'b0;
    logic          par_typ = 1'b0;
    logic [PW-1:0] prescale = '0;
    logic          tx_ready, busy, tx_out;

    int checks = 0;
    int failures = 0;

    uart_tx #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .par_en   (par_en),
        .par_typ  (par_typ),
        .prescale (prescale),
        .tx_ready (tx_ready),
        .busy     (busy),
        .tx_out   (tx_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt, input logic [PW-1:0] ps);
        tx_data  = d;
        par_en   = pe;
        par_typ  = pt;
        prescale = ps;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    // Called in the first cycle after accept. seq[b] is the expected line
    // value of bit time b (start, data, optional parity); stop bits follow.
    task automatic check_frame(input string tag, input int n, input logic [15:0] seq, input int p);
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < p; c++) begin
                check_eq($sformatf("%s_b%0d_c%0d", tag, b, c), tx_out, seq[b]);
                check_eq($sformatf("%s_busy_b%0d", tag, b), busy, 1);
                check_eq($sformatf("%s_rdy_b%0d", tag, b), tx_ready, 0);
                tick();
            end
        end
        for (int s = 0; s < STOP_BITS * p; s++) begin
            check_eq($sformatf("%s_stop%0d", tag, s), tx_out, 1);
            check_eq($sformatf("%s_stopbusy%0d", tag, s), busy, 1);
            tick();
        end
        check_eq({tag, "_ready"}, tx_ready, 1);
        check_eq({tag, "_nbusy"}, busy, 0);
        check_eq({tag, "_idle"}, tx_out, 1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_txout", tx_out, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ready", tx_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_idle", tx_out, 1);

        // 0xA5, even parity (0): 0,1,0,1,0,0,1,0,1,0 then stop
        send(8'hA5, 1'b1, 1'b0, 6'd1);
        check_frame("even_a5", 10, 16'h014A, 1);

        // Same byte, odd parity flips only the parity bit
        send(8'hA5, 1'b1, 1'b1, 6'd1);
        check_frame("odd_a5", 10, 16'h034A, 1);

        // prescale=4, no parity, 0x00: 36 low cycles then stop
        send(8'h00, 1'b0, 1'b0, 6'd4);
        check_frame("ps4_00", 9, 16'h0000, 4);

        // prescale=0 behaves as 1
        send(8'hA5, 1'b1, 1'b0, 6'd0);
        check_frame("ps0_a5", 10, 16'h014A, 1);

        // Busy rejection: valid held, data/par_typ changed after accept
        tx_data  = 8'h5A;
        par_en   = 1'b1;
        par_typ  = 1'b0;
        prescale = 6'd1;
        tx_valid = 1'b1;
        tick();
        tx_data  = 8'h3C;
        par_typ  = 1'b1;
        check_frame("hold_5a", 10, 16'h00B4, 1);
        tick();
        tx_valid = 1'b0;
        check_frame("next_3c", 10, 16'h0278, 1);

        // Reset during data bit 3 (prescale 2)
        send(8'h00, 1'b0, 1'b0, 6'd2);
        repeat (8) tick();
        check_eq("mid_low", tx_out, 0);
        check_eq("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_txout", tx_out, 1);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_ready", tx_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq($sformatf("after_rst_line%0d", i), tx_out, 1);
            check_eq($sformatf("after_rst_rdy%0d", i), tx_ready, 1);
        end

        // Normal operation resumes after the aborted frame
        send(8'hA5, 1'b1, 1'b1, 6'd1);
        check_frame("resume_a5", 10, 16'h034A, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter: serializes one parallel byte per frame onto a single line, LSB first.
- Frame order: start bit, data bits, optional parity bit, stop bit(s).
- It is the transmit counterpart of the UART_RX path. Its parity convention matches the receiver's parity check, so a loopback of tx_out into RX yields par_err = 0.
- Bit timing comes from an internal prescale counter: each bit is held for a programmable number of clk cycles.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_W, 6, width of the prescale input (clk cycles per bit).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- tx_data  in  DATA_WIDTH  byte to transmit
- tx_valid  in  1  tx_data is valid; transfer occurs on tx_valid && tx_ready
- par_en  in  1  1 = insert parity bit
- par_typ  in  1  1 = odd parity, 0 = even parity
- prescale  in  PRESCALE_W  clk cycles per bit; 0 is treated as 1
- tx_ready  out  1  block can accept a byte (IDLE state)
- busy  out  1  frame in progress
- tx_out  out  1  serial line, idle high

Behaviour:
- Reset is asynchronous: clk and rst_n are already decided as stated above.
- Reset values: tx_out = 1, busy = 0, tx_ready = 1, state = IDLE, all counters and registers = 0.
- Reset asserted mid-frame aborts the frame immediately. The line returns high, and no partial frame resumes after release.
- FSM states:
  - IDLE -> START on accept.
  - START -> DATA after one bit time.
  - DATA -> PARITY after DATA_WIDTH bits if par_en was latched as 1, otherwise DATA -> STOP.
  - PARITY -> STOP after one bit time.
  - STOP -> IDLE after one bit time.
- Accept (cycle N):
  - tx_data, par_en, par_typ and prescale are latched.
  - The parity bit is computed from the latched data: even = ^data, odd = ~^data.
  - Changes to these inputs after acceptance have no effect on the current frame.
- Latency: tx_out drives the start bit (0) from cycle N+1.
- Bit timing: each bit is held exactly P clk cycles, with P = max(prescale, 1).
  - The bit-time counter runs 0..P-1.
  - The bit advances on the cycle where counter == P-1.
- Data bits are sent LSB first. A bit counter tracks 0..DATA_WIDTH-1.
- tx_ready = 1 only in IDLE. busy = !tx_ready. Both are registered, state-derived outputs.
- tx_valid while busy is ignored: the byte is not captured and there is no error flag.
  - The upstream block must hold tx_valid until it sees tx_ready.
- Back-to-back frames: STOP returns to IDLE for at least one cycle, so there is a minimum of 1 idle-high cycle between consecutive frames.
- Frame length, excluding the idle gap:
  - (1 + DATA_WIDTH + par_en + 1) * P cycles.
  - With UART_TX_STOP2_EN defined, one more P.
- tx_out is driven from a register, so the output is glitch-free.

Optional Feature:
- Macro: UART_TX_STOP2_EN.
- Defined: STOP is held for 2 bit times (2*P cycles) before returning to IDLE. tx_out stays 1 throughout.
- Undefined: a single stop bit (P cycles).
- Ports and all other behaviour are identical in both builds.

Decomposition:
- Shared package uart_pkg, containing:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - PAR_ODD = 1'b1 and PAR_EVEN = 1'b0;
  - the default DATA_WIDTH.
- RX and TX both import uart_pkg, so parity encoding is defined in one place.
- One sub-module, uart_tx_serializer:
  - holds the DATA_WIDTH shift register and the bit counter;
  - loads on accept and shifts on the bit-advance strobe from the FSM;
  - asserts ser_done on the last data bit.
- The FSM, prescale counter and parity generation stay in uart_tx.

Test Plan:
- Basic frame: prescale=1, par_en=1, par_typ=0, tx_data=0xA5.
  - tx_out sequence from N+1: 0,1,0,1,0,0,1,0,1,0,1.
  - tx_ready returns to 1 at N+12.
- Odd parity: same stimulus with par_typ=1.
  - Parity bit = 1; all other bits unchanged.
  - Loopback into RX gives par_err = 0.
- Prescale and no parity: prescale=4, par_en=0, tx_data=0x00.
  - Start plus 8 data bits give tx_out low for 36 cycles, then 4 cycles high for the stop bit.
  - Total 40 cycles; busy high throughout.
- Busy rejection and latching: tx_valid held with 0x3C while busy, and tx_data/par_typ changed mid-frame.
  - The current frame is unchanged.
  - 0x3C is sent only after tx_ready rises, with at least 1 idle-high cycle between frames.
- Reset mid-frame: assert rst_n low during DATA bit 3.
  - tx_out = 1, busy = 0, tx_ready = 1 immediately.
  - After release, the line stays high until the next tx_valid.
- Boundary cases:
  - prescale = 0 behaves identically to prescale = 1.
  - With UART_TX_STOP2_EN defined, the stop bit lasts 2*P cycles; otherwise P cycles.
